// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU-side initiator and dmem_responder.
// Carries req_be_i only when DMEM_RESPONDER_BYTE_STROBE_EN is defined.
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
`ifdef DMEM_RESPONDER_BYTE_STROBE_EN
  logic [3:0]  req_be_i;
`endif
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
`ifdef DMEM_RESPONDER_BYTE_STROBE_EN
    output req_be_i,
`endif
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
`ifdef DMEM_RESPONDER_BYTE_STROBE_EN
    input  req_be_i,
`endif
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Optional byte-strobed stores when DMEM_RESPONDER_BYTE_STROBE_EN is defined.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  dmem_responder_if.slave bus
);
  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        ready_en;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          access;
  logic          addr_err;
  logic          mem_we;
  logic [AW-1:0] word_idx;
  logic [3:0]    wr_be;

`ifdef DMEM_RESPONDER_BYTE_STROBE_EN
  logic [3:0] cap_be;
  assign wr_be = cap_be;
`else
  assign wr_be = 4'hF;
`endif

  // ready_en keeps the request port closed until the first edge after reset release.
  assign bus.req_ready_o = ready_en && (state == ST_IDLE);
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign access          = (state == ST_WAIT) && (cnt == 4'd0);
  assign word_idx        = cap_addr[AW+1:2];
  assign addr_err        = (cap_addr[1:0] != 2'b00) || (cap_addr[31:AW+2] != '0);
  assign mem_we          = access && cap_we && !addr_err;

  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_rdata;
  assign bus.rsp_err_o   = rsp_err;

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ready_en  <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
`ifdef DMEM_RESPONDER_BYTE_STROBE_EN
      cap_be    <= '0;
`endif
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_we    <= bus.req_we_i;
            cap_addr  <= bus.req_addr_i;
            cap_wdata <= bus.req_wdata_i;
`ifdef DMEM_RESPONDER_BYTE_STROBE_EN
            cap_be    <= bus.req_be_i;
`endif
            cnt       <= LAT_M1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            // Loads see the word as it stood before this edge.
            rsp_valid <= 1'b1;
            rsp_err   <= addr_err;
            rsp_rdata <= (cap_we || addr_err) ? '0 : mem[word_idx];
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; a reset only drops the pending write via mem_we.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY 2 main instance plus a LATENCY 1 instance
// for back-to-back throughput. Byte-strobe steps run when DMEM_RESPONDER_BYTE_STROBE_EN is defined.
module tb_dmem_responder;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) u_dut1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus1)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One complete LATENCY-2 transaction with rsp_ready_i raised as soon as the response shows.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    check({tag, " ready"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    step();
    bus.req_valid_i = 1'b0;
    check({tag, " rsp0"}, 32'(bus.rsp_valid_o), 32'd0);
    check({tag, " busy"}, 32'(bus.req_ready_o), 32'd0);
    step();
    check({tag, " rsp1"}, 32'(bus.rsp_valid_o), 32'd0);
    step();
    check({tag, " rsp2"}, 32'(bus.rsp_valid_o), 32'd1);
    check({tag, " rdata"}, bus.rsp_rdata_o, exp_rdata);
    check({tag, " err"}, 32'(bus.rsp_err_o), 32'(exp_err));
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    check({tag, " done"}, 32'(bus.rsp_valid_o), 32'd0);
  endtask

  logic [31:0] l1_addr  [6];
  logic [31:0] l1_wdata [6];
  logic        l1_we    [6];
  logic [31:0] l1_exp   [6];
  int          acc_edge [6];

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.rsp_ready_i  = 1'b0;
    bus1.req_valid_i = 1'b0;
    bus1.req_we_i    = 1'b0;
    bus1.req_addr_i  = '0;
    bus1.req_wdata_i = '0;
    bus1.rsp_ready_i = 1'b1;
`ifdef DMEM_RESPONDER_BYTE_STROBE_EN
    bus.req_be_i  = 4'hF;
    bus1.req_be_i = 4'hF;
`endif

    // Reset state and release.
    repeat (3) step();
    check("rst ready", 32'(bus.req_ready_o), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst rdata", bus.rsp_rdata_o, 32'd0);
    check("rst err", 32'(bus.rsp_err_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check("rel ready pre-edge", 32'(bus.req_ready_o), 32'd0);
    step();
    check("rel ready", 32'(bus.req_ready_o), 32'd1);

    // Store then load.
    xact("st 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("ld 0x10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Misaligned and out-of-range requests; 0x200 would alias word 0 if range were unchecked.
    xact("st 0x0", 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("ld 0x13", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    xact("st 0x200", 1'b1, 32'h200, 32'h12345678, 32'h0, 1'b1);
    xact("ld 0x0", 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
    xact("st 0x1FC", 1'b1, 32'h1FC, 32'h0BADC0DE, 32'h0, 1'b0);
    xact("ld 0x1FC", 1'b0, 32'h1FC, 32'h0, 32'h0BADC0DE, 1'b0);

    // Response held for 5 cycles while a competing store is presented.
    xact("st 0x40", 1'b1, 32'h40, 32'h13579BDF, 32'h0, 1'b0);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'h40;
    step();
    bus.req_we_i    = 1'b1;
    bus.req_wdata_i = 32'hFFFFFFFF;
    step();
    step();
    check("hold first", 32'(bus.rsp_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold%0d valid", i), 32'(bus.rsp_valid_o), 32'd1);
      check($sformatf("hold%0d rdata", i), bus.rsp_rdata_o, 32'h13579BDF);
      check($sformatf("hold%0d err", i), 32'(bus.rsp_err_o), 32'd0);
      check($sformatf("hold%0d ready", i), 32'(bus.req_ready_o), 32'd0);
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    check("hold released", 32'(bus.rsp_valid_o), 32'd0);
    xact("ld 0x40 after hold", 1'b0, 32'h40, 32'h0, 32'h13579BDF, 1'b0);

    // Reset during WAIT of a store drops it.
    xact("st 0x20", 1'b1, 32'h20, 32'h11, 32'h0, 1'b0);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 32'h20;
    bus.req_wdata_i = 32'h55;
    step();
    bus.req_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("midrst ready", 32'(bus.req_ready_o), 32'd0);
    check("midrst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    step();
    step();
    check("midrst no rsp", 32'(bus.rsp_valid_o), 32'd0);
    rst_i = 1'b1;
    step();
    check("midrst rsp after", 32'(bus.rsp_valid_o), 32'd0);
    check("midrst ready after", 32'(bus.req_ready_o), 32'd1);
    xact("ld 0x20 kept", 1'b0, 32'h20, 32'h0, 32'h11, 1'b0);

`ifdef DMEM_RESPONDER_BYTE_STROBE_EN
    xact("be clr 0x30", 1'b1, 32'h30, 32'h0, 32'h0, 1'b0);
    bus.req_be_i = 4'b0101;
    xact("be st 0x30", 1'b1, 32'h30, 32'hAABBCCDD, 32'h0, 1'b0);
    bus.req_be_i = 4'b0000;
    xact("be0 st 0x30", 1'b1, 32'h30, 32'h99999999, 32'h0, 1'b0);
    bus.req_be_i = 4'b0010;
    xact("be ld 0x30", 1'b0, 32'h30, 32'h0, 32'h00BB00DD, 1'b0);
    bus.req_be_i = 4'hF;
`endif

    // LATENCY 1 back-to-back with rsp_ready_i held high: 3 stores then 3 loads.
    for (int i = 0; i < 3; i++) begin
      l1_we[i]      = 1'b1;
      l1_addr[i]    = 32'(4 * i);
      l1_wdata[i]   = 32'hA0 + 32'(i);
      l1_exp[i]     = 32'h0;
      l1_we[i+3]    = 1'b0;
      l1_addr[i+3]  = 32'(4 * i);
      l1_wdata[i+3] = 32'h0;
      l1_exp[i+3]   = 32'hA0 + 32'(i);
    end
    begin
      int a = 0;
      int r = 0;
      bit pending = 1'b0;
      bus1.req_valid_i = 1'b1;
      bus1.req_we_i    = l1_we[0];
      bus1.req_addr_i  = l1_addr[0];
      bus1.req_wdata_i = l1_wdata[0];
      for (int k = 0; k < 40; k++) begin
        if (bus1.rsp_valid_o && r < 6) begin
          check($sformatf("l1 rsp%0d latency", r), 32'(k), 32'(acc_edge[r] + 1));
          check($sformatf("l1 rsp%0d rdata", r), bus1.rsp_rdata_o, l1_exp[r]);
          check($sformatf("l1 rsp%0d err", r), 32'(bus1.rsp_err_o), 32'd0);
          r++;
        end
        if (pending) begin
          pending = 1'b0;
          a++;
          if (a < 6) begin
            bus1.req_we_i    = l1_we[a];
            bus1.req_addr_i  = l1_addr[a];
            bus1.req_wdata_i = l1_wdata[a];
          end else begin
            bus1.req_valid_i = 1'b0;
          end
        end
        if (bus1.req_valid_i && bus1.req_ready_o) begin
          pending     = 1'b1;
          acc_edge[a] = k + 1;
          if (a > 0) check($sformatf("l1 spacing%0d", a), 32'(acc_edge[a] - acc_edge[a-1]), 32'd3);
        end
        step();
      end
      check("l1 responses seen", 32'(r), 32'd6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL provide parameter DEPTH_WORDS, default 128: number of 32-bit words in the storage array; power of two, 16 to 1024.
REQ-002 The block SHALL provide parameter LATENCY, default 2: cycles from request acceptance to response valid; range 1 to 15.
REQ-003 The block SHALL provide port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL provide port req_valid_i, input, 1 bit: the CPU-side initiator presents a request.
REQ-006 The block SHALL provide port req_ready_o, output, 1 bit: the block can accept a request this cycle.
REQ-007 The block SHALL provide port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL provide port req_addr_i, input, 32 bits: byte address.
REQ-009 The block SHALL provide port req_wdata_i, input, 32 bits: store data.
REQ-010 The block SHALL provide port rsp_valid_o, output, 1 bit: a response is presented.
REQ-011 The block SHALL provide port rsp_ready_i, input, 1 bit: the initiator accepts the response.
REQ-012 The block SHALL provide port rsp_rdata_o, output, 32 bits: load data; 0 for stores and errors.
REQ-013 The block SHALL provide port rsp_err_o, output, 1 bit: the request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have three states, IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-015 Acceptance SHALL occur on an edge where req_valid_i and req_ready_o are both 1; we, addr and wdata SHALL be captured at that edge and the FSM SHALL move to WAIT with the latency counter loaded with LATENCY-1.
REQ-016 In WAIT the counter SHALL decrement each cycle; on the edge where it is 0, the access SHALL be performed, rsp_valid_o SHALL rise and the FSM SHALL move to RESP, so that rsp_valid_o is first high LATENCY cycles after the acceptance edge.
REQ-017 When LATENCY = 1, WAIT SHALL last exactly one cycle.
REQ-018 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; an error SHALL be raised when addr[1:0] != 0 or addr >= 4*DEPTH_WORDS.
REQ-019 An error request SHALL NOT modify storage and SHALL return rsp_err_o = 1 with rsp_rdata_o = 0.
REQ-020 A store SHALL write the captured wdata to the word and return rsp_rdata_o = 0 with rsp_err_o = 0.
REQ-021 A load SHALL return the word content as of the access edge.
REQ-022 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL be held stable until an edge with rsp_ready_i = 1, which SHALL return the FSM to IDLE with rsp_valid_o = 0.
REQ-023 A new request SHALL be accepted no earlier than the cycle after response acceptance, giving a minimum spacing of LATENCY+2 cycles per transaction.
REQ-024 req_* inputs SHALL be ignored outside IDLE.
REQ-025 rsp_ready_i SHALL be ignored outside RESP.
REQ-026 A store followed by a load to the same address SHALL return the stored data.

Reset
REQ-027 While rst_i = 0 the block SHALL immediately force state IDLE, counter 0, req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0 and rsp_err_o = 0.
REQ-028 req_ready_o SHALL go to 1 on the first rising edge after rst_i returns to 1.
REQ-029 A transaction in flight at reset SHALL be dropped without a response.
REQ-030 A store that has not reached its access edge when reset is asserted SHALL NOT be written.
REQ-031 The storage array SHALL NOT be reset.

Configuration
REQ-032 When macro DMEM_RESPONDER_BYTE_STROBE_EN is defined, the block SHALL add input port req_be_i, 4 bits, captured at acceptance; a store SHALL update only the bytes whose bit is set (bit n selects bits 8n+7:8n); a store with be = 0 SHALL succeed without modifying storage; load responses SHALL be unaffected.
REQ-033 When DMEM_RESPONDER_BYTE_STROBE_EN is not defined, port req_be_i SHALL NOT exist and every store SHALL write all 4 bytes.

Verification
REQ-034 The bench SHALL cover: reset release, then store addr 0x10 data 0xDEADBEEF, then load 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid_o first high exactly 2 cycles after each acceptance.
REQ-035 The bench SHALL cover: load addr 0x13 -> err 1, rdata 0; then store 0x200 with DEPTH_WORDS 128 -> err 1, and a load from word 0 is unchanged.
REQ-036 The bench SHALL cover: load response held with rsp_ready_i = 0 for 5 cycles -> rsp_valid_o, rsp_rdata_o and rsp_err_o stable, req_ready_o stays 0, and a new req_valid_i during this time is ignored.
REQ-037 The bench SHALL cover: rst_i pulled low in WAIT of a store 0x55 to 0x20 -> no response and word 0x20 keeps its prior value 0x11.
REQ-038 The bench SHALL cover, with the macro defined: word 0x30 = 0x00000000, store 0xAABBCCDD with be 4'b0101 -> a load from 0x30 returns 0x00BB00DD.
REQ-039 The bench SHALL cover: LATENCY 1 back-to-back loads with rsp_ready_i tied to 1 -> one transaction every 3 cycles.
